hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage pipeline. It decides, every cycle, whether each pipeline register advances, holds, takes a bubble or is flushed. It drives the PC register, IF/ID, ID/EXE and EXE/MEM from three sources: load-use hazards, taken branches resolved in ID, and multi-cycle EXE operations such as mul/div. A small FSM and a countdown counter hold EXE occupied for a fixed latency.

---
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Purpose : pipeline sequencing control (stall / bubble / flush / freeze) for the 5-stage pipeline.
// Latency : control outputs are combinational from the current ID/EXE fields and the registered FSM state; exe_busy is a decode of flops.
// Backpr. : a multi-cycle EXE op freezes PC, IF/ID, ID/EXE and bubbles EXE/MEM for MUL_LAT-1 cycles; load-use stalls one cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   ID side  : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken
//   EXE side : ewreg, em2reg, e_dst, e_multi
//   Controls : pc_stall, ifid_stall, ifid_flush, idexe_bubble, idexe_hold, exemem_bubble, exe_busy
//   Stats    : stall_cnt, flush_cnt (live only when HAZ_STATS_EN is defined, otherwise tied to 0)
//
// Optional feature macro: HAZ_STATS_EN (saturating stall/flush event counters).

module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,   // total EXE occupancy of a multi-cycle op, 2..16
  parameter int CNT_W   = 16   // statistics counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       e_dst,
  input  logic             e_multi,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             idexe_hold,
  output logic             exemem_bubble,
  output logic             exe_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The first EXE cycle is spent in IDLE, the last one in BUSY with cnt==0,
  // so the countdown starts at MUL_LAT-2.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

  state_t     state;
  logic [3:0] cnt;
  logic       lu;
  logic       freeze;

  // Load-use: a load in EXE feeds a register the ID instruction reads. $0 never hazards.
  always_comb begin
    lu = id_valid & ewreg & em2reg & (e_dst != 5'd0) &
         ((id_use_rs & (id_rs == e_dst)) | (id_use_rt & (id_rt == e_dst)));
  end

  // Freeze covers the op's first EXE cycle (IDLE, e_multi) and every BUSY cycle
  // except the final one, where the op drains into MEM and ID is evaluated normally.
  always_comb begin
    freeze = ((state == IDLE) & e_multi) | ((state == BUSY) & (cnt != 4'd0));
  end

  // Priority when not frozen: load-use stall beats taken-branch flush.
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idexe_bubble  = 1'b0;
    idexe_hold    = 1'b0;
    exemem_bubble = 1'b0;
    if (rst) begin
      if (freeze) begin
        pc_stall      = 1'b1;
        ifid_stall    = 1'b1;
        idexe_hold    = 1'b1;
        exemem_bubble = 1'b1;
      end else if (lu) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idexe_bubble = 1'b1;
      end else if (id_branch_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // exe_busy marks the BUSY cycles that still freeze upstream; it drops in the
  // final EXE cycle so it lines up with the freeze window's tail.
  assign exe_busy = (state == BUSY) & (cnt != 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (e_multi) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // e_multi is deliberately not looked at here: the op still sitting
          // in EXE in its final cycle must not retrigger the sequence.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose : scoreboard bench for hazard_stall_ctrl with directed vectors.
// Latency : each vector is applied just after a rising edge and its expected outputs are checked on the next falling edge.
// Backpr. : none; one vector per cycle, the monitor pops one expectation per falling edge.

module tb_hazard_stall_ctrl;

  localparam int CNT_W = 16;

  // Expected output bit order: {pc_stall, ifid_stall, ifid_flush, idexe_bubble, idexe_hold, exemem_bubble, exe_busy}
  localparam logic [6:0] Z    = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] BR   = 7'b0010000;
  localparam logic [6:0] FRZ  = 7'b1100110;
  localparam logic [6:0] FRZB = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs, id_use_rt, id_branch_taken;
  logic [4:0]       id_rs, id_rt, e_dst;
  logic             ewreg, em2reg, e_multi;
  logic             pc_stall, ifid_stall, ifid_flush, idexe_bubble, idexe_hold, exemem_bubble, exe_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    int               tag;
    logic [6:0]       o;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_no   = 0;
  int   stall_acc = 0;
  int   flush_acc = 0;
  bit   done = 1'b0;

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_branch_taken (id_branch_taken),
    .ewreg           (ewreg),
    .em2reg          (em2reg),
    .e_dst           (e_dst),
    .e_multi         (e_multi),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idexe_bubble    (idexe_bubble),
    .idexe_hold      (idexe_hold),
    .exemem_bubble   (exemem_bubble),
    .exe_busy        (exe_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Apply one vector just after the rising edge and queue its expected response.
  task automatic step(input logic r, input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic br,
                      input logic ew, input logic em, input logic [4:0] ed, input logic mul,
                      input logic [6:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = vld; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_branch_taken = br; ewreg = ew; em2reg = em; e_dst = ed; e_multi = mul;
    if (!r) begin
      stall_acc = 0;
      flush_acc = 0;
    end
    e.tag = vec_no;
    e.o   = o;
`ifdef HAZ_STATS_EN
    e.sc  = CNT_W'(stall_acc);
    e.fc  = CNT_W'(flush_acc);
`else
    e.sc  = '0;
    e.fc  = '0;
`endif
    exp_q.push_back(e);
    if (r) begin
      stall_acc += int'(o[6]);
      flush_acc += int'(o[4]);
    end
    vec_no++;
  endtask

  // Monitor: every falling edge presents one cycle of outputs for the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {pc_stall, ifid_stall, ifid_flush, idexe_bubble, idexe_hold, exemem_bubble, exe_busy};
      n_checks++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL ctrl vec%0d: got %b expected %b (pc,ifid_st,flush,bub,hold,exmem,busy)", e.tag, act, e.o);
      end
      n_checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL stats vec%0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.tag, stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch_taken = 1'b0; ewreg = 1'b0; em2reg = 1'b0; e_dst = '0; e_multi = 1'b0;

    //   rst vld rs     rt     urs  urt  br   ew   em   ed     mul  expected
    // Reset state
    step(0, 0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1, Z);
    step(0, 1, 5'd5, 5'd5, 1, 1, 0, 1, 1, 5'd5, 0, Z);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);
    // Load-use on rt, then load moves to MEM
    step(1, 1, 5'd1, 5'd5, 0, 1, 0, 1, 1, 5'd5, 0, LU);
    step(1, 1, 5'd1, 5'd5, 0, 1, 0, 0, 0, 5'd9, 0, Z);
    // Load-use on rs
    step(1, 1, 5'd7, 5'd2, 1, 0, 0, 1, 1, 5'd7, 0, LU);
    // $0 destination never hazards
    step(1, 1, 5'd0, 5'd3, 1, 0, 0, 1, 1, 5'd0, 0, Z);
    // ALU producer (not a load)
    step(1, 1, 5'd1, 5'd5, 0, 1, 0, 1, 0, 5'd5, 0, Z);
    // Load not writing a register, invalid ID, unused operand field
    step(1, 1, 5'd1, 5'd5, 0, 1, 0, 0, 1, 5'd5, 0, Z);
    step(1, 0, 5'd5, 5'd5, 1, 1, 0, 1, 1, 5'd5, 0, Z);
    step(1, 1, 5'd6, 5'd2, 0, 1, 0, 1, 1, 5'd6, 0, Z);
    // Taken branch alone, then with a load-use in the same cycle
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, BR);
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 1, 5'd2, 0, LU);
    // Multi-cycle op with a taken branch held in ID throughout
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 0, 5'd8, 1, FRZ);   // T
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 0, 5'd8, 1, FRZB);  // T+1
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 0, 5'd8, 1, FRZB);  // T+2
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 1, 0, 5'd8, 1, BR);    // T+3: e_multi still high, not re-sampled
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);     // T+4: back in IDLE
    // Multi-cycle op with a load-use pending: ignored while frozen, honoured in the final cycle
    step(1, 1, 5'd4, 5'd0, 1, 0, 0, 1, 1, 5'd4, 1, FRZ);
    step(1, 1, 5'd4, 5'd0, 1, 0, 0, 1, 1, 5'd4, 1, FRZB);
    step(1, 1, 5'd4, 5'd0, 1, 0, 0, 1, 1, 5'd4, 1, FRZB);
    step(1, 1, 5'd4, 5'd0, 1, 0, 0, 1, 1, 5'd4, 1, LU);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);
    // Reset in the middle of BUSY aborts the op
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, FRZ);   // T
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, Z);     // T+1: reset asserted
    step(0, 0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, Z);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);     // released: IDLE, no freeze
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);
    step(1, 1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, BR);
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, Z);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete, %0d checks so far", n_checks);
      $fatal(1, "timeout");
    end
  end

endmodule
